// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, comparator bias, arctangent table and sequencer states for the rotation CORDIC.
package cordic_pkg;
   localparam int WIDTH = 32;
   localparam logic [WIDTH-1:0] SIGN_BIAS = 32'h8000_0000;
   localparam logic [WIDTH-1:0] CORDIC_K_Q230 = 32'h26DD_3B6A;
   // Q2.30 atan(2^-i), rounded to nearest
   localparam logic [WIDTH-1:0] ATAN_TABLE [0:31] = '{
      32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
      32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
      32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
      32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
      32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
      32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
      32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
      32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
   };
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational CORDIC micro-rotation; neg selects d=-1, otherwise d=+1.
module cordic_microrot
   import cordic_pkg::*;
(
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] y_i,
   input  logic        [WIDTH-1:0] phi_i,
   input  logic        [4:0]       shift,
   input  logic                    neg,
   output logic signed [WIDTH-1:0] x_o,
   output logic signed [WIDTH-1:0] y_o,
   output logic        [WIDTH-1:0] phi_o
);
   logic signed [WIDTH-1:0] xs, ys;
   always_comb begin
      xs = x_i >>> shift;
      ys = y_i >>> shift;
      x_o = neg ? x_i + ys : x_i - ys;
      y_o = neg ? y_i - xs : y_i + xs;
      phi_o = neg ? phi_i - ATAN_TABLE[shift] : phi_i + ATAN_TABLE[shift];
   end
endmodule

// File: rtl/cordic_rotation_seq.sv
// cordic_rotation_seq: iterative rotation-mode CORDIC sequencer steering each micro-rotation
// from an external magnitude comparator fed with sign-biased target and accumulated angles.
module cordic_rotation_seq
   import cordic_pkg::*;
#(
   parameter int ITER = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] theta_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] phi_out,
   output logic [WIDTH-1:0] cmp_a,
   output logic [WIDTH-1:0] cmp_b,
   input  logic             cmp_gr,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   output logic             cmp_err
);
   if (ITER < 1 || ITER > 31) begin : g_iter_range
      $error("ITER must be in 1..31");
   end
   localparam logic [4:0] LAST = 5'(ITER - 1);
   state_t state_q, state_d;
   logic [4:0] i_q, i_d;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, x_nx, y_nx;
   logic [WIDTH-1:0] phi_q, phi_d, theta_q, theta_d, phi_nx;
   logic legal, neg;
   // only a lone lt turns the rotation negative; any illegal code falls back to d=+1
   assign legal = $onehot({cmp_gr, cmp_lt, cmp_eq});
   assign neg = cmp_lt & legal;
   cordic_microrot u_rot (
      .x_i(x_q), .y_i(y_q), .phi_i(phi_q), .shift(i_q), .neg(neg),
      .x_o(x_nx), .y_o(y_nx), .phi_o(phi_nx)
   );
   always_comb begin
      state_d = state_q;
      i_d = i_q;
      busy_d = busy_q;
      done_d = 1'b0;
      err_d = err_q;
      x_d = x_q;
      y_d = y_q;
      phi_d = phi_q;
      theta_d = theta_q;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            i_d = '0;
            busy_d = 1'b1;
            err_d = 1'b0;
            x_d = x_in;
            y_d = y_in;
            phi_d = '0;
            theta_d = theta_in;
         end
         RUN: begin
            x_d = x_nx;
            y_d = y_nx;
            phi_d = phi_nx;
            i_d = i_q + 5'd1;
            err_d = err_q | ~legal;
            state_d = (i_q == LAST) ? DONE : RUN;
         end
         DONE: begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         i_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         x_q <= '0;
         y_q <= '0;
         phi_q <= '0;
         theta_q <= '0;
      end else begin
         state_q <= state_d;
         i_q <= i_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
         x_q <= x_d;
         y_q <= y_d;
         phi_q <= phi_d;
         theta_q <= theta_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign cmp_err = err_q;
   assign x_out = x_q;
   assign y_out = y_q;
   assign phi_out = phi_q;
   assign cmp_a = theta_q ^ SIGN_BIAS;
   assign cmp_b = phi_q ^ SIGN_BIAS;
endmodule

// File: tb/tb_cordic_rotation_seq.sv
// tb_cordic_rotation_seq: checks the CORDIC sequencer against a real-arithmetic reference model
// and hand-computed angle/latency expectations, with a comparator stub that can inject illegal codes.
module tb_cordic_rotation_seq;
   localparam int N1 = 16;
   localparam int N2 = 4;
   localparam logic [31:0] BIAS = 32'h8000_0000;
   localparam logic [31:0] KX = 32'h26DD3B6A;
   localparam logic [31:0] PI4 = 32'h3243F6A9;
   localparam logic [31:0] NPI4 = 32'hCDBC0957;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic start1 = 1'b0, busy1, done1, gr1, lt1, eq1, err1;
   logic [31:0] x1 = '0, y1 = '0, t1 = '0, xo1, yo1, po1, a1, b1;
   logic start2 = 1'b0, busy2, done2, gr2, lt2, eq2, err2;
   logic [31:0] x2 = '0, y2 = '0, t2 = '0, xo2, yo2, po2, a2, b2;
   int n_tests = 0, n_fail = 0;
   int m_cnt = 0, inj_it = -1, m_x = 0, m_y = 0, m_p = 0;
   logic m_err = 1'b0;
   logic [31:0] m_th = '0;
   logic inj_on;
   assign inj_on = (inj_it >= 0) && (m_cnt == inj_it + 1);
   assign gr1 = inj_on | (a1 > b1);
   assign lt1 = inj_on | (a1 < b1);
   assign eq1 = !inj_on && (a1 == b1);
   assign gr2 = a2 > b2;
   assign lt2 = a2 < b2;
   assign eq2 = a2 == b2;
   cordic_rotation_seq #(.ITER(N1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .x_in(x1), .y_in(y1), .theta_in(t1),
      .busy(busy1), .done(done1), .x_out(xo1), .y_out(yo1), .phi_out(po1),
      .cmp_a(a1), .cmp_b(b1), .cmp_gr(gr1), .cmp_lt(lt1), .cmp_eq(eq1), .cmp_err(err1)
   );
   cordic_rotation_seq #(.ITER(N2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .x_in(x2), .y_in(y2), .theta_in(t2),
      .busy(busy2), .done(done2), .x_out(xo2), .y_out(yo2), .phi_out(po2),
      .cmp_a(a2), .cmp_b(b2), .cmp_gr(gr2), .cmp_lt(lt2), .cmp_eq(eq2), .cmp_err(err2)
   );
   function automatic int atan_ref(input int k);
      real t;
      t = 1.0;
      for (int j = 0; j < k; j++) t = t / 2.0;
      return $rtoi($atan(t) * 1073741824.0 + 0.5);
   endfunction
   // angle-steered rotation in plain signed integer arithmetic; iteration inj is forced to d=+1
   function automatic void rotate(input int x0, input int y0, input int th, input int n,
                                  input int inj, output int xe, output int ye, output int pe);
      int x, y, p, xn;
      bit pos;
      x = x0; y = y0; p = 0;
      for (int k = 0; k < n; k++) begin
         pos = (k == inj) || (th >= p);
         xn = pos ? x - (y >>> k) : x + (y >>> k);
         y = pos ? y + (x >>> k) : y - (x >>> k);
         x = xn;
         p = pos ? p + atan_ref(k) : p - atan_ref(k);
      end
      xe = x; ye = y; pe = p;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic chk_near(input string nm, input logic [31:0] act, input logic [31:0] exp, input int tol);
      int d;
      n_tests++;
      d = $signed(act) - $signed(exp);
      if (d > tol || d < -tol) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h +/- %h", nm, act, exp, tol);
      end
   endtask
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt <= 0;
         m_err <= 1'b0;
         m_th <= '0;
      end else begin
         if (inj_on) m_err <= 1'b1;
         if ((m_cnt == 0 || m_cnt == N1 + 2) && start1) begin
            m_cnt <= 1;
            m_err <= 1'b0;
            m_th <= t1;
            rotate($signed(x1), $signed(y1), $signed(t1), N1, inj_it, m_x, m_y, m_p);
         end else if (m_cnt == N1 + 2) m_cnt <= 0;
         else if (m_cnt != 0) m_cnt <= m_cnt + 1;
      end
   end
   always @(negedge clk) begin
      chk("busy", {31'd0, busy1}, {31'd0, m_cnt >= 1 && m_cnt <= N1 + 1});
      chk("done", {31'd0, done1}, {31'd0, m_cnt == N1 + 2});
      chk("cmp_err", {31'd0, err1}, {31'd0, m_err});
      chk("cmp_a", a1, m_th ^ BIAS);
      if (m_cnt == N1 + 2) begin
         chk("model_x", xo1, m_x);
         chk("model_y", yo1, m_y);
         chk("model_phi", po1, m_p);
      end
   end
   task automatic do_op(input logic [31:0] x, input logic [31:0] th, input int inj, input int poke,
                        output int lat, output logic lt_first);
      x1 = x; y1 = '0; t1 = th; inj_it = inj; start1 = 1'b1;
      lat = -1; lt_first = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start1 = (c == poke);
         if (c == 1) lt_first = lt1;
         if (done1) begin
            lat = c - 1;
            break;
         end
      end
      start1 = 1'b0;
   endtask
   int lat, pulses;
   logic ltf;
   logic [31:0] xa, ya, pa;
   initial begin
      chk("atan_ref0", atan_ref(0), 32'h3243F6A9);
      chk("atan_ref1", atan_ref(1), 32'h1DAC6705);
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_x", xo1, 32'd0);
      chk("rst_phi", po1, 32'd0);
      chk("rst_cmp_a", a1, 32'h80000000);
      chk("rst_cmp_b", b1, 32'h80000000);
      rst = 1'b0;
      @(negedge clk);
      do_op(KX, PI4, -1, 0, lat, ltf);
      chk("lat_pi4", lat, 17);
      chk("first_lt_pi4", {31'd0, ltf}, 32'd0);
      chk_near("x_pi4", xo1, 32'h2D413CCD, 32'h10000);
      chk_near("y_pi4", yo1, 32'h2D413CCD, 32'h10000);
      chk_near("phi_pi4", po1, PI4, 32'h10000);
      xa = xo1; ya = yo1; pa = po1;
      do_op(KX, NPI4, -1, 0, lat, ltf);
      chk("lat_npi4", lat, 17);
      chk("first_lt_npi4", {31'd0, ltf}, 32'd1);
      chk_near("x_npi4", xo1, 32'h2D413CCD, 32'h10000);
      chk_near("y_npi4", yo1, 32'hD2BEC333, 32'h10000);
      chk_near("phi_npi4", po1, NPI4, 32'h10000);
      do_op(KX, PI4, -1, 4, lat, ltf);
      chk("lat_poke", lat, 17);
      chk("x_poke", xo1, xa);
      chk("y_poke", yo1, ya);
      chk("phi_poke", po1, pa);
      do_op(KX, PI4, 2, 0, lat, ltf);
      chk("lat_inj", lat, 17);
      chk("err_inj", {31'd0, err1}, 32'd1);
      do_op(KX, NPI4, -1, 0, lat, ltf);
      chk("err_clear", {31'd0, err1}, 32'd0);
      x1 = KX; t1 = PI4; inj_it = -1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy1}, 32'd0);
      chk("abort_done", {31'd0, done1}, 32'd0);
      chk("abort_cmp_a", a1, 32'h80000000);
      chk("abort_cmp_b", b1, 32'h80000000);
      chk("abort_x", xo1, 32'd0);
      chk("abort_y", yo1, 32'd0);
      chk("abort_phi", po1, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (30) begin
         @(negedge clk);
         pulses += int'(done1);
      end
      chk("abort_no_done", pulses, 0);
      x2 = KX; y2 = '0; t2 = PI4; start2 = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         chk("held_done", {31'd0, done2}, {31'd0, n >= N2 + 1 && (n - N2 - 1) % (N2 + 2) == 0});
         chk("held_busy", {31'd0, busy2}, {31'd0, !(n >= N2 + 1 && (n - N2 - 1) % (N2 + 2) == 0)});
      end
      start2 = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cordic_rotation_seq.md
Name: cordic_rotation_seq

Overview:
- Iterative rotation-mode CORDIC sequencer that sits directly downstream of the 32-bit magnitude comparator.
- It drives the comparator's A/B operands with the target angle and the accumulated angle, and consumes the gr/lt/eq result to choose each micro-rotation direction.
- It owns the x/y/phi registers, the iteration counter and the start/done handshake to the processor control.

Parameters:
- ITER, 16, number of micro-rotations, legal range 1..31. ITER=0 or >31 is a static assertion failure.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in  in  32  signed Q2.30 initial x, pre-scaled by K=0.607253.
- y_in  in  32  signed Q2.30 initial y.
- theta_in  in  32  signed Q2.30 target angle, |theta| <= 1.7433 rad.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; outputs valid.
- x_out  out  32  signed Q2.30 cos-path result.
- y_out  out  32  signed Q2.30 sin-path result.
- phi_out  out  32  final accumulated angle.
- cmp_a  out  32  comparator operand A = theta_reg XOR 0x80000000.
- cmp_b  out  32  comparator operand B = phi_reg XOR 0x80000000.
- cmp_gr  in  1  comparator A>B.
- cmp_lt  in  1  comparator A<B.
- cmp_eq  in  1  comparator A==B.
- cmp_err  out  1  sticky: illegal comparator code seen; cleared on accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE, i=0, busy=0, done=0, cmp_err=0; x/y/phi/theta regs=0. Outputs therefore read x_out=y_out=phi_out=0 and cmp_a=cmp_b=0x80000000. Reset mid-RUN aborts with no done pulse.
- Sign handling: MSB bias makes the unsigned comparator order equal to signed order. The comparator is combinational, so its result is consumed in the same cycle.
- IDLE:
  - start=1 at an edge: load x=x_in, y=y_in, theta=theta_in, phi=0, i=0, clear cmp_err.
  - Go to RUN; busy=1 from the next cycle.
- RUN, one micro-rotation per cycle:
  - Direction: d=+1 if cmp_gr or cmp_eq, d=-1 if cmp_lt.
  - Updates:
    - x <= x - d*(y>>>i)
    - y <= y + d*(x>>>i)
    - phi <= phi + d*ATAN_TABLE[i]
  - Shifts are arithmetic and all sums wrap modulo 2^32 with no saturation. The old x and y are used for both updates.
  - i <= i+1. When i==ITER-1, go to DONE.
- Illegal comparator code (gr&lt, or none of gr/lt/eq, or eq together with gr or lt): set cmp_err=1, use d=+1, continue.
- DONE, one cycle: done=1, busy=0, then return to IDLE.
  - x_out/y_out/phi_out are driven from the registers and hold until the next accepted start.
- Latency: start sampled at edge k → done high in the cycle following edge k+ITER+1 (ITER RUN cycles + 1 DONE cycle).
- start while busy or in DONE is ignored (not queued). start held high continuously retriggers from IDLE, giving back-to-back operations every ITER+2 cycles.
- No output gain compensation; the caller supplies K-prescaled x_in.

Decomposition:
- Package cordic_pkg:
  - WIDTH=32
  - SIGN_BIAS=32'h8000_0000
  - ATAN_TABLE[0:31], Q2.30 atan(2^-i) rounded to nearest, entry 0 = 0x3243F6A9
  - CORDIC_K_Q230=0x26DD3B6A
  - state enum {IDLE, RUN, DONE}
- One sub-module: cordic_microrot. Combinational datapath taking (x, y, phi, i, d) and producing next x/y/phi with the barrel shifts. The sequencer holds the FSM, counter and registers.

Test Plan:
- Reset mid-RUN (assert rst at iteration 5) → busy=0, done never pulses, cmp_a=cmp_b=0x80000000, all outputs 0.
- ITER=16, x_in=0x26DD3B6A, y_in=0, theta_in=0x3243F6A9 (pi/4) → done exactly 17 cycles after the start edge; x_out and y_out each within ±0x10000 of 0x2D413CCD; phi_out within ±0x10000 of theta.
- theta_in=0xCDBC0957 (-pi/4), same x_in → x_out≈0x2D413CCD, y_out≈0xD2BEC333 (±0x10000); first-cycle d=-1 checked via cmp_lt=1.
- Pulse start again while busy at iteration 3 → ignored; single done pulse; results identical to the undisturbed run.
- Comparator stub forces gr=lt=1 at iteration 2 → cmp_err=1 and held through done; the next accepted start clears it.
- start held high for 40 cycles with ITER=4 → done pulses at cycles 5, 11, 17, ... (period 6); busy low exactly during DONE/IDLE cycles.
